seg7_scan_ctrl: RTL and testbench

//   Time-multiplexes one shared seg7 BCD-to-segment decoder across NUM_DIGITS common-anode digits.

---
 rtl/seg7_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller. It shares one external BCD-to-segment
// decoder across all digits and swaps in new display words only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    lz_en,
    output logic [3:0]              dec_in,
    input  logic [6:0]              dec_out,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [0:0] ST_SCAN = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    logic [0:0]              state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [4*NUM_DIGITS-1:0] active_r;
    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic                    pending_r;

    logic                    advance_s;
    logic                    wrap_s;
    logic [IDX_W-1:0]        idx_next_s;
    logic                    xfer_s;
    logic                    upper_zero_s;
    logic                    blank_s;

    assign load_ready = ~pending_r;
    assign xfer_s     = load_valid & ~pending_r;
    assign dec_in     = active_r[{idx_r, 2'b00} +: 4];

    // Decide when the current digit slot ends and where the index goes next.
    always_comb begin
        advance_s = 1'b0;
        case (state_r)
            ST_SCAN: advance_s = (cnt_r == SCAN_LAST) && (BLANK_CYCLES == 0);
            ST_GAP:  advance_s = (cnt_r == GAP_LAST);
            default: advance_s = 1'b0;
        endcase
        wrap_s     = advance_s && (idx_r == IDX_LAST);
        idx_next_s = wrap_s ? '0 : idx_r + IDX_W'(1);
    end

    // Leading-zero blanking: this digit and every more significant digit are zero.
    always_comb begin
        upper_zero_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            upper_zero_s = upper_zero_s &
                           ((i < int'(idx_r)) || (active_r[4*i +: 4] == 4'h0));
        end
        blank_s = lz_en && (idx_r != '0) && upper_zero_s;
    end

    // Scan sequencer: lit time per digit, optional anti-ghost gap, digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_SCAN;
            idx_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_SCAN: begin
                    if (cnt_r == SCAN_LAST) begin
                        cnt_r <= '0;
                        if (BLANK_CYCLES == 0) begin
                            idx_r <= idx_next_s;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r   <= '0;
                        idx_r   <= idx_next_s;
                        state_r <= ST_SCAN;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_SCAN;
                    idx_r   <= '0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Word intake; a word accepted on the wrap cycle waits for the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r  <= '0;
            shadow_r  <= '0;
            pending_r <= 1'b0;
        end else if (wrap_s && pending_r) begin
            active_r  <= shadow_r;
            pending_r <= 1'b0;
        end else if (xfer_s) begin
            shadow_r  <= load_data;
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Registered pin drivers, one cycle behind the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n       <= '1;
            seg_n      <= 7'h7F;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap_s;
            if (state_r == ST_SCAN) begin
                an_n  <= ~(NUM_DIGITS'(1) << idx_r);
                seg_n <= blank_s ? 7'h7F : dec_out;
            end else begin
                an_n  <= '1;
                seg_n <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: one instance with a one-cycle gap, one without, both checked
// every cycle against a frame-timing model computed from cycle position arithmetic.
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lz_en = 1'b0;
    logic        load_valid [2];
    logic [15:0] load_data  [2];
    logic        load_ready [2];
    logic [3:0]  dec_in     [2];
    logic [6:0]  dec_out    [2];
    logic [6:0]  seg_n      [2];
    logic [3:0]  an_n       [2];
    logic        frame_tick [2];

    int n_checks = 0;
    int n_fail   = 0;
    int rand_mode = 0;

    int          m_t       [2];
    logic [15:0] m_active  [2];
    logic [15:0] m_shadow  [2];
    logic        m_pending [2];
    logic [3:0]  e_an      [2];
    logic [6:0]  e_seg     [2];
    logic        e_tick    [2];

    always #5 clk = ~clk;

    // External common-anode decoder, active-low gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    assign dec_out[0] = seg7(dec_in[0]);
    assign dec_out[1] = seg7(dec_in[1]);

    seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid[0]), .load_ready(load_ready[0]),
        .load_data(load_data[0]), .lz_en(lz_en), .dec_in(dec_in[0]), .dec_out(dec_out[0]),
        .seg_n(seg_n[0]), .an_n(an_n[0]), .frame_tick(frame_tick[0])
    );

    seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(0)) dut_nogap (
        .clk(clk), .rst(rst), .load_valid(load_valid[1]), .load_ready(load_ready[1]),
        .load_data(load_data[1]), .lz_en(lz_en), .dec_in(dec_in[1]), .dec_out(dec_out[1]),
        .seg_n(seg_n[1]), .an_n(an_n[1]), .frame_tick(frame_tick[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        if (obs !== expd) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expd, $time);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0;
            m_active[k] = 16'h0;
            m_shadow[k] = 16'h0;
            m_pending[k] = 1'b0;
            e_an[k] = 4'hF;
            e_seg[k] = 7'h7F;
            e_tick[k] = 1'b0;
        end
    endtask

    task automatic check_reset_pins();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_an_n[%0d]", k), 32'(an_n[k]), 32'h0000000F);
            check_eq($sformatf("rst_seg_n[%0d]", k), 32'(seg_n[k]), 32'h0000007F);
            check_eq($sformatf("rst_ready[%0d]", k), 32'(load_ready[k]), 32'h1);
            check_eq($sformatf("rst_tick[%0d]", k), 32'(frame_tick[k]), 32'h0);
        end
    endtask

    // Called at a falling edge: check this cycle, drive inputs, predict the next cycle.
    task automatic step();
        int per, frame, p, d;
        bit gap, blank_d;
        logic [3:0] nib;
        if (rand_mode == 1) begin
            lz_en = 1'($urandom_range(0, 1));
            for (int k = 0; k < 2; k++) begin
                load_valid[k] = ($urandom_range(0, 3) == 0);
                load_data[k]  = 16'($urandom);
            end
        end else if (rand_mode == 2) begin
            for (int k = 0; k < 2; k++) begin
                load_valid[k] = 1'b1;
                load_data[k]  = 16'($urandom);
            end
        end
        for (int k = 0; k < 2; k++) begin
            per   = R + ((k == 0) ? 1 : 0);
            frame = N * per;
            p     = m_t[k] % frame;
            d     = p / per;
            gap   = (p % per) >= R;
            nib   = 4'((m_active[k] >> (4 * d)) & 16'h000F);
            check_eq($sformatf("an_n[%0d]", k), 32'(an_n[k]), 32'(e_an[k]));
            check_eq($sformatf("seg_n[%0d]", k), 32'(seg_n[k]), 32'(e_seg[k]));
            check_eq($sformatf("frame_tick[%0d]", k), 32'(frame_tick[k]), 32'(e_tick[k]));
            check_eq($sformatf("load_ready[%0d]", k), 32'(load_ready[k]), 32'(!m_pending[k]));
            check_eq($sformatf("dec_in[%0d]", k), 32'(dec_in[k]), 32'(nib));
            blank_d   = lz_en && (d != 0) && ((m_active[k] >> (4 * d)) == 16'h0);
            e_an[k]   = gap ? 4'hF : ~(4'b0001 << d);
            e_seg[k]  = (gap || blank_d) ? 7'h7F : seg7(nib);
            e_tick[k] = (p == frame - 1);
            if (e_tick[k] && m_pending[k]) begin
                m_active[k]  = m_shadow[k];
                m_pending[k] = 1'b0;
            end else if (load_valid[k] && !m_pending[k]) begin
                m_shadow[k]  = load_data[k];
                m_pending[k] = 1'b1;
            end
            m_t[k]++;
        end
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_pins();
        reset_model();
        for (int k = 0; k < 2; k++) load_valid[k] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] w);
        for (int k = 0; k < 2; k++) begin
            load_valid[k] = 1'b1;
            load_data[k]  = w;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            load_valid[k] = 1'b0;
            load_data[k]  = 16'h0;
        end
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_pins();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic, then a reset in the middle of a scan.
        rand_mode = 1;
        run(37);
        rand_mode = 0;
        lz_en = 1'b0;
        mid_reset();

        // 1234 then 5678 held back-to-back: 5678 waits a full frame behind 1234.
        load_all(16'h1234);
        step();
        load_all(16'h5678);
        run(65);
        for (int k = 0; k < 2; k++) load_valid[k] = 1'b0;
        run(20);

        // Leading-zero blanking with 0070, then all zeros.
        mid_reset();
        lz_en = 1'b1;
        load_all(16'h0070);
        step();
        for (int k = 0; k < 2; k++) load_valid[k] = 1'b0;
        run(42);
        load_all(16'h0000);
        step();
        for (int k = 0; k < 2; k++) load_valid[k] = 1'b0;
        run(42);

        // Fully random, then valid held high so loads land on frame_tick cycles.
        rand_mode = 1;
        run(500);
        lz_en = 1'b0;
        rand_mode = 2;
        run(120);
        rand_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
